// File: rtl/gait_sequencer.sv
// gait_sequencer - multi-joint gait engine for the biped.
//
// Holds a writable table of joint-angle poses and steps through them in order.
// Every joint slews toward its target in the active pose by 1 degree per
// prescaler tick. A pose advances only once all joints have arrived and the
// pose's optional foot-contact gate is satisfied. One servo PWM per joint.
//
// Optional feature macro: GAIT_CYCLE_TIMER_EN adds the cycle_clks output, which
// reports the clock count of the last complete gait cycle.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset      synchronous, active-high
//   start      level; run the sequence while high, finish slew and hold when low
//   step_div   clocks per 1 degree slew step (0 behaves as 1)
//   seq_len    number of active poses, sampled when entering ADVANCE
//   fsr        foot-contact flag (already synchronised), only looked at in GATE
//   tbl_we     table write strobe
//   tbl_pose   pose index to write
//   tbl_joint  joint index to write
//   tbl_angle  angle to write, clamped to 180
//   tbl_gate   pose gate bit, written together with joint 0
//   pwm        one servo pulse per joint
//   cur_pose   pose currently targeted
//   all_done   every joint is at its target (combinational)
//   busy       sequencer FSM not idle
//   cycle_clks clocks per full gait cycle (GAIT_CYCLE_TIMER_EN only)
module gait_sequencer #(
  parameter int NUM_JOINTS  = 6,
  parameter int NUM_POSES   = 8,
  parameter int ANGLE_W     = 8,
  parameter int HOME_ANGLE  = 90,
  parameter int PERIOD_CLKS = 1000000,
  parameter int PULSE_MIN   = 25000,
  parameter int PULSE_MAX   = 125000,
  localparam int PW = $clog2(NUM_POSES),
  localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [23:0]           step_div,
  input  logic [PW:0]           seq_len,
  input  logic                  fsr,
  input  logic                  tbl_we,
  input  logic [PW-1:0]         tbl_pose,
  input  logic [JW-1:0]         tbl_joint,
  input  logic [ANGLE_W-1:0]    tbl_angle,
  input  logic                  tbl_gate,
  output logic [NUM_JOINTS-1:0] pwm,
  output logic [PW-1:0]         cur_pose,
  output logic                  all_done,
  output logic                  busy
`ifdef GAIT_CYCLE_TIMER_EN
  ,
  output logic [31:0]           cycle_clks
`endif
);

  localparam int unsigned PULSE_STEP = (PULSE_MAX - PULSE_MIN) / 180;

  typedef enum logic [1:0] {IDLE, MOVE, GATE, ADVANCE} state_t;

  // Angles above the servo range are stored as the 180 degree end stop.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    if (32'(a) > 32'd180) begin
      return ANGLE_W'(180);
    end else begin
      return a;
    end
  endfunction

  // Pulse high time for a given angle, 32-bit unsigned arithmetic.
  function automatic logic [31:0] angle_to_width(input logic [ANGLE_W-1:0] a);
    return 32'(PULSE_MIN) + 32'(a) * 32'(PULSE_STEP);
  endfunction

  logic [ANGLE_W-1:0] tbl_r    [NUM_POSES][NUM_JOINTS];
  logic [NUM_POSES-1:0] gate_r;
  logic [ANGLE_W-1:0] ang_r    [NUM_JOINTS];
  logic [ANGLE_W-1:0] target_s [NUM_JOINTS];
  logic [31:0]        width_s  [NUM_JOINTS];
  logic [31:0]        width_r  [NUM_JOINTS];
  logic [NUM_JOINTS-1:0] pwm_r;
  logic [23:0]        pre_r;
  logic [23:0]        div_s;
  logic               tick_s;
  logic               all_done_s;
  state_t             state_r;
  state_t             state_n;
  logic [PW-1:0]      cur_pose_r;
  logic [PW-1:0]      nxt_pose_r;
  logic [PW:0]        inc_s;
  logic               wrap_s;
  logic               busy_r;
  logic [31:0]        frame_r;

  assign pwm      = pwm_r;
  assign cur_pose = cur_pose_r;
  assign all_done = all_done_s;
  assign busy     = busy_r;

  // Pose table: reset to home, writable at any time; out-of-range joints ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_POSES; p++) begin
        for (int j = 0; j < NUM_JOINTS; j++) begin
          tbl_r[p][j] <= ANGLE_W'(HOME_ANGLE);
        end
      end
      gate_r <= '0;
    end else if (tbl_we && (32'(tbl_joint) < 32'(NUM_JOINTS))) begin
      tbl_r[tbl_pose][tbl_joint] <= clamp_angle(tbl_angle);
      if (tbl_joint == JW'(0)) begin
        gate_r[tbl_pose] <= tbl_gate;
      end
    end
  end

  // Active targets, per-joint PWM widths and the arrival flag.
  always_comb begin
    all_done_s = 1'b1;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      target_s[j] = tbl_r[cur_pose_r][j];
      width_s[j]  = angle_to_width(ang_r[j]);
      if (ang_r[j] != target_s[j]) begin
        all_done_s = 1'b0;
      end else begin
        all_done_s = all_done_s;
      end
    end
  end

  // A zero divider would never tick, so it behaves as a divider of one.
  always_comb begin
    div_s  = (step_div == 24'd0) ? 24'd1 : step_div;
    tick_s = (pre_r >= (div_s - 24'd1));
  end

  // Shared slew prescaler; >= keeps it from running away if step_div shrinks.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r <= 24'd0;
    end else if (tick_s) begin
      pre_r <= 24'd0;
    end else begin
      pre_r <= pre_r + 24'd1;
    end
  end

  // Joint angles step one degree toward their targets on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        ang_r[j] <= ANGLE_W'(HOME_ANGLE);
      end
    end else if (tick_s) begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        if (ang_r[j] < target_s[j]) begin
          ang_r[j] <= ang_r[j] + ANGLE_W'(1);
        end else if (ang_r[j] > target_s[j]) begin
          ang_r[j] <= ang_r[j] - ANGLE_W'(1);
        end
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Sequencer next state; dropping start only takes effect once in GATE,
  // so an in-flight slew always completes.
  always_comb begin
    state_n = state_r;
    inc_s   = {1'b0, cur_pose_r} + (PW+1)'(1);
    wrap_s  = (inc_s >= seq_len);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = MOVE;
        end else begin
          state_n = IDLE;
        end
      end
      MOVE: begin
        if (all_done_s) begin
          state_n = GATE;
        end else begin
          state_n = MOVE;
        end
      end
      GATE: begin
        if (!start) begin
          state_n = IDLE;
        end else if (!gate_r[cur_pose_r] || fsr) begin
          state_n = ADVANCE;
        end else begin
          state_n = GATE;
        end
      end
      ADVANCE: state_n = MOVE;
      default: state_n = IDLE;
    endcase
  end

  // Next pose is resolved on entry to ADVANCE (that is when seq_len counts)
  // and becomes the active pose on the edge leaving ADVANCE. An interrupted
  // sequence parks on its current pose.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_pose_r <= '0;
      nxt_pose_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      if ((state_r == GATE) && (state_n == ADVANCE)) begin
        nxt_pose_r <= wrap_s ? '0 : inc_s[PW-1:0];
      end
      if (state_r == ADVANCE) begin
        cur_pose_r <= nxt_pose_r;
      end
      busy_r <= (state_n != IDLE);
    end
  end

  // Shared PWM frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_r <= 32'd0;
    end else if (frame_r >= 32'(PERIOD_CLKS - 1)) begin
      frame_r <= 32'd0;
    end else begin
      frame_r <= frame_r + 32'd1;
    end
  end

  // Widths latch at frame start so a pulse never changes mid-frame; at count 0
  // the fresh width is used directly so the pulse covers counts 0..width-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        width_r[j] <= 32'd0;
      end
      pwm_r <= '0;
    end else begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        if (frame_r == 32'd0) begin
          width_r[j] <= width_s[j];
          pwm_r[j]   <= (width_s[j] != 32'd0);
        end else begin
          pwm_r[j]   <= (frame_r < width_r[j]);
        end
      end
    end
  end

`ifdef GAIT_CYCLE_TIMER_EN
  logic [31:0] cyc_cnt_r;
  logic [31:0] cycle_clks_r;

  assign cycle_clks = cycle_clks_r;

  // Gait cycle timer: an ADVANCE landing on pose 0 closes one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_r    <= 32'd0;
      cycle_clks_r <= 32'd0;
    end else if ((state_r == ADVANCE) && (nxt_pose_r == '0)) begin
      cycle_clks_r <= cyc_cnt_r;
      cyc_cnt_r    <= 32'd0;
    end else if (cyc_cnt_r != 32'hFFFF_FFFF) begin
      cyc_cnt_r    <= cyc_cnt_r + 32'd1;
    end
  end
`endif

endmodule
